// File: rtl/mx_blk_scaler.sv
// -----------------------------------------------------------------------------
// mx_blk_scaler
//
// Streaming MX block front-end that sits directly upstream of the RNE element
// rounder. It collects one block of block_size signed elements and finds the
// block's shared exponent from the OR of all element magnitudes. It then
// replays the block one element per beat as sign, block-normalised magnitude,
// shared scale and the rounder's shift operand.
//
// Configuration macro: MX_SCALER_PINGPONG_EN
//   undefined : a single block buffer. Filling and draining alternate, so the
//               peak rate is block_size beats per 2*block_size cycles.
//   defined   : two block buffers. Filling one bank overlaps draining the
//               other, so back-to-back blocks stream at one element per cycle.
//
// Handshake (both sides): a beat transfers on a rising clock edge where valid
// and ready are both high. A source holds valid and its payload stable until
// that edge. Here o_valid never drops inside a block, and every output stays
// unchanged while o_valid && !i_ready.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active-high
//   i_valid      upstream element valid
//   o_ready      element accepted when i_valid && o_ready
//   i_num        signed two's complement input element
//   i_shift      per-block rounder shift, sampled on the block's first beat
//   o_valid      output element valid
//   i_ready      downstream ready
//   o_sign       element sign (1 = negative)
//   o_num        |element| << lz_blk, unsigned
//   o_shift      i_shift captured for this block
//   o_scale      shared exponent = width_i-1-lz_blk, 0 for an all-zero block
//   o_zero       block is all zero, constant over the block
//   o_first      first element of block
//   o_last       last element of block
//   o_dbg_state  per-bank FSM state, bit b = 1 when bank b is in DRAIN
// -----------------------------------------------------------------------------
module mx_blk_scaler #(
    parameter int width_i     = 8,
    parameter int block_size  = 32,
    parameter int width_shift = 8,
    localparam int scale_w    = $clog2(width_i) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [width_i-1:0]     i_num,
    input  logic [width_shift-1:0] i_shift,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_sign,
    output logic [width_i-1:0]     o_num,
    output logic [width_shift-1:0] o_shift,
    output logic [scale_w-1:0]     o_scale,
    output logic                   o_zero,
    output logic                   o_first,
    output logic                   o_last,
    output logic [1:0]             o_dbg_state
);

    localparam int cnt_w = $clog2(block_size);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(block_size - 1);
    localparam logic [scale_w-1:0] top_bit = scale_w'(width_i - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // One FSM per bank. Without ping-pong only bank 0 ever leaves FILL.
    state_t bank_state      [2];
    state_t bank_state_next [2];

    logic                   wr_bank;
    logic                   rd_bank;
    logic [cnt_w-1:0]       wr_cnt;
    logic [cnt_w-1:0]       rd_cnt;
    logic [width_i-1:0]     acc;

    // Block storage and the per-bank block attributes.
    logic [width_i-1:0]     mag_mem   [2][block_size];
    logic [block_size-1:0]  sign_mem  [2];
    logic [scale_w-1:0]     lz_mem    [2];
    logic [width_shift-1:0] shift_mem [2];
    logic [1:0]             zero_mem;

    logic                   wr_fire;
    logic                   wr_last;
    logic                   rd_fire;
    logic                   rd_last;
    logic                   in_sign;
    logic [width_i-1:0]     in_mag;
    logic [width_i-1:0]     acc_next;

    // Count of leading zeros. Returns width_i when the value is zero.
    function automatic logic [scale_w-1:0] clz(input logic [width_i-1:0] v);
        logic [scale_w-1:0] n;
        logic               found;
        n     = scale_w'(width_i);
        found = 1'b0;
        for (int i = width_i - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = scale_w'(width_i - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // Input side: magnitude and block OR accumulation
    // -------------------------------------------------------------------------
    // Negating -2^(width_i-1) wraps back to 2^(width_i-1). Read as an unsigned
    // value that is exactly the magnitude, so no extra bit is needed. A zero
    // input always has a sign bit of 0.
    assign in_sign  = i_num[width_i-1];
    assign in_mag   = in_sign ? (~i_num + width_i'(1)) : i_num;

    // The accumulator restarts on the first beat of every block. This avoids
    // needing a separate clear cycle between blocks.
    assign acc_next = ((wr_cnt == '0) ? '0 : acc) | in_mag;

    assign wr_fire  = i_valid && o_ready;
    assign wr_last  = wr_fire && (wr_cnt == cnt_last);
    assign rd_fire  = o_valid && i_ready;
    assign rd_last  = rd_fire && (rd_cnt == cnt_last);

    // -------------------------------------------------------------------------
    // Bank pointers
    // -------------------------------------------------------------------------
`ifdef MX_SCALER_PINGPONG_EN
    // Banks complete in order, so each pointer toggles when its bank finishes.
    // rd_bank always points at the oldest full bank.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_last) begin
                rd_bank <= ~rd_bank;
            end
        end
    end
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bank_state[0] <= FILL;
            bank_state[1] <= FILL;
        end else begin
            bank_state[0] <= bank_state_next[0];
            bank_state[1] <= bank_state_next[1];
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_next[b] = bank_state[b];
            case (bank_state[b])
                FILL: begin
                    if (wr_last && (wr_bank == 1'(b))) begin
                        bank_state_next[b] = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_last && (rd_bank == 1'(b))) begin
                        bank_state_next[b] = FILL;
                    end
                end
                default: bank_state_next[b] = FILL;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // All outputs are decoded from registered state only, so they cannot
    // change while a beat is stalled. The payload is forced to zero whenever
    // o_valid is low. As a result the reset values fall out without having to
    // reset the storage arrays.
    always_comb begin
        o_ready     = (bank_state[wr_bank] == FILL);
        o_valid     = (bank_state[rd_bank] == DRAIN);
        o_dbg_state = {bank_state[1] == DRAIN, bank_state[0] == DRAIN};
        o_sign      = 1'b0;
        o_num       = '0;
        o_shift     = '0;
        o_scale     = '0;
        o_zero      = 1'b0;
        o_first     = 1'b0;
        o_last      = 1'b0;
        if (o_valid) begin
            o_sign  = sign_mem[rd_bank][rd_cnt];
            o_num   = mag_mem[rd_bank][rd_cnt] << lz_mem[rd_bank];
            o_shift = shift_mem[rd_bank];
            o_zero  = zero_mem[rd_bank];
            o_scale = zero_mem[rd_bank] ? '0 : (top_bit - lz_mem[rd_bank]);
            o_first = (rd_cnt == '0);
            o_last  = (rd_cnt == cnt_last);
        end
    end

    // -------------------------------------------------------------------------
    // Counters and per-bank block attributes
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            acc      <= '0;
            zero_mem <= '0;
            for (int b = 0; b < 2; b++) begin
                lz_mem[b]    <= '0;
                shift_mem[b] <= '0;
            end
        end else begin
            if (wr_fire) begin
                // block_size is a power of two, so the counter wraps naturally.
                wr_cnt <= wr_cnt + 1'b1;
                acc    <= acc_next;
                if (wr_cnt == '0) begin
                    shift_mem[wr_bank] <= i_shift;
                end
                if (wr_last) begin
                    lz_mem[wr_bank]   <= clz(acc_next);
                    zero_mem[wr_bank] <= (acc_next == '0);
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Element storage (no reset: the contents are only read once a bank is
    // full)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_fire) begin
            mag_mem[wr_bank][wr_cnt]  <= in_mag;
            sign_mem[wr_bank][wr_cnt] <= in_sign;
        end
    end

endmodule

// File: tb/tb_mx_blk_scaler.sv
`timescale 1ns/1ps
module tb_mx_blk_scaler;

    localparam int W      = 8;
    localparam int BS     = 4;
    localparam int SW     = 8;
    localparam int SCW    = 4;
    localparam int BEAT_W = 1 + W + SW + SCW + 3;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_num;
    logic [SW-1:0] i_shift;
    logic          o_valid;
    logic          i_ready;
    logic          o_sign;
    logic [W-1:0]  o_num;
    logic [SW-1:0] o_shift;
    logic [SCW-1:0] o_scale;
    logic          o_zero;
    logic          o_first;
    logic          o_last;
    logic [1:0]    o_dbg_state;

    mx_blk_scaler #(
        .width_i     (W),
        .block_size  (BS),
        .width_shift (SW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_num       (i_num),
        .i_shift     (i_shift),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sign      (o_sign),
        .o_num       (o_num),
        .o_shift     (o_shift),
        .o_scale     (o_scale),
        .o_zero      (o_zero),
        .o_first     (o_first),
        .o_last      (o_last),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [BEAT_W-1:0] exp_q[$];
    int   out_cyc_q[$];
    bit   rec = 1'b0;
    int   ready_low = 0;
    int   rdy_mode = 0;          // 0: always ready, 1: random, 2: manual
    logic ready_manual = 1'b0;
    logic ready_rnd = 1'b1;
    int   blk[BS];
    logic [BEAT_W-1:0] obs_beat;

    assign obs_beat = {o_sign, o_num, o_shift, o_scale, o_zero, o_first, o_last};

    always_comb begin
        i_ready = 1'b1;
        if (rdy_mode == 1) i_ready = ready_rnd;
        else if (rdy_mode == 2) i_ready = ready_manual;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            ready_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (rec && !o_ready) ready_low++;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(o_valid), 64'(0));
                end else begin
                    check("beat", 64'(obs_beat), 64'(exp_q[0]));
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        if (rec) out_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_block(input logic [SW-1:0] sh);
        int mag[BS];
        int orv;
        int top;
        int lz;
        logic [BEAT_W-1:0] b;
        orv = 0;
        for (int i = 0; i < BS; i++) begin
            mag[i] = (blk[i] < 0) ? -blk[i] : blk[i];
            orv = orv | mag[i];
        end
        top = -1;
        for (int k = 0; k < W; k++) if (((orv >> k) & 1) == 1) top = k;
        lz = (top < 0) ? W : (W - 1 - top);
        for (int i = 0; i < BS; i++) begin
            b = {(blk[i] < 0), 8'(mag[i] * (1 << lz)), sh, 4'((top < 0) ? 0 : top),
                 (top < 0), (i == 0), (i == BS - 1)};
            exp_q.push_back(b);
        end
    endtask

    // ---------------- driver tasks (enter/leave at posedge+1) ----------------
    task automatic push_beat(input logic [W-1:0] v, input logic [SW-1:0] sh, output int acc_cyc);
        int guard;
        guard = 0;
        i_valid = 1'b1;
        i_num   = v;
        i_shift = sh;
        @(negedge i_clk);
        while (!o_ready && guard < 200) begin
            guard++;
            @(negedge i_clk);
        end
        if (guard >= 200) check("ready_timeout", 64'(o_ready), 64'(1));
        acc_cyc = cyc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_block(input logic [SW-1:0] sh, input int gap_max, output int first_cyc);
        int c;
        int g;
        first_cyc = 0;
        for (int i = 0; i < BS; i++) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            if (g > 0) idle(g);
            push_beat(8'(blk[i]), (i == 0) ? sh : 8'($urandom), c);
            if (i == 0) first_cyc = c;
        end
        model_block(sh);
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_valid(input string tag);
        int guard;
        guard = 0;
        while (!o_valid && guard < 100) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        check(tag, 64'(o_valid), 64'(1));
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_ready", 64'(o_ready), 64'(1));
        check("rst_outputs", 64'(obs_beat), 64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        int c;
        int k;
        int e;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_num   = '0;
        i_shift = '0;
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        do_reset();

        // Basic block
        rdy_mode = 0;
        blk = '{3, -5, 1, 0};
        send_block(8'd2, 0, t0);
        wait_drain("drain_basic");

        // All-zero block
        blk = '{0, 0, 0, 0};
        send_block(8'd9, 1, t0);
        wait_drain("drain_zero");

        // Full-scale extremes
        blk = '{-128, 1, 2, 127};
        send_block(8'd5, 0, t0);
        wait_drain("drain_extreme");

        // Downstream stall on beat 1 for 3 cycles
        rdy_mode     = 2;
        ready_manual = 1'b0;
        blk = '{10, -20, 30, -40};
        send_block(8'd77, 0, t0);
        idle(0);
        wait_valid("stall_valid");
        ready_manual = 1'b1;
        @(posedge i_clk);
        #1;
        ready_manual = 1'b0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        check("stall_pending", 64'(exp_q.size()), 64'(3));
        ready_manual = 1'b1;
        wait_drain("drain_stall");

        // Reset mid-fill, then a clean block
        rdy_mode = 0;
        push_beat(8'd7, 8'd1, c);
        push_beat(8'd7, 8'd1, c);
        do_reset();
        blk = '{4, 4, 4, 4};
        send_block(8'd3, 0, t0);
        wait_drain("drain_after_fill_rst");
        idle(4);

        // Reset mid-drain: the pending block must vanish
        rdy_mode     = 2;
        ready_manual = 1'b0;
        blk = '{1, 2, 3, 4};
        send_block(8'd6, 0, t0);
        idle(0);
        wait_valid("drain_rst_valid");
        do_reset();
        ready_manual = 1'b1;
        idle(8);

        // Three back-to-back blocks at full rate
        rdy_mode  = 0;
        ready_low = 0;
        out_cyc_q.delete();
        rec = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < BS; i++) blk[i] = $urandom_range(0, 255) - 128;
            send_block(8'($urandom), 0, c);
            if (b == 0) t0 = c;
        end
        idle(0);
        wait_drain("drain_b2b");
        rec = 1'b0;
        check("b2b_count", 64'(out_cyc_q.size()), 64'(3 * BS));
        for (int i = 0; i < 3 * BS; i++) begin
`ifdef MX_SCALER_PINGPONG_EN
            check("b2b_cycle", 64'(out_cyc_q[i]), 64'(t0 + BS + i));
`else
            check("b2b_cycle", 64'(out_cyc_q[i]), 64'(t0 + BS + 2 * BS * (i / BS) + (i % BS)));
`endif
        end
`ifdef MX_SCALER_PINGPONG_EN
        check("b2b_ready_low", 64'(ready_low), 64'(0));
`else
        check("b2b_ready_low", 64'(ready_low), 64'(3 * BS));
`endif
        idle(3);

        // Randomized blocks, random input gaps and downstream backpressure
        rdy_mode = 1;
        for (int b = 0; b < 30; b++) begin
            for (int i = 0; i < BS; i++) begin
                k = $urandom_range(0, 7);
                e = int'($urandom & ((1 << k) - 1));
                if ($urandom_range(0, 1) == 1) e = -e;
                if ($urandom_range(0, 15) == 0) e = -128;
                if (b % 8 == 5) e = 0;
                blk[i] = e;
            end
            send_block(8'($urandom), 2, c);
        end
        idle(0);
        wait_drain("drain_random");
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
